// File: rtl/atconv_pkg.sv
// Shared constants and types for the dilated-conv engine and its layer-memory readback path.
package atconv_pkg;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 13;

  localparam logic L0_SEL = 1'b0;
  localparam logic L1_SEL = 1'b1;

  localparam int unsigned L1_WORDS = 1024;
  localparam int unsigned L0_WORDS = 4096;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO for layer_drain. DEPTH must be a power of two. Reset clears the storage and the pointers.
module drain_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 14
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_en_c, rd_en_c;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the head slot in the same cycle.
  assign wr_en_c = push_i && (!full_o || pop_i);
  assign rd_en_c = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_ptr_q] <= wdata_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (rd_en_c) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({wr_en_c, rd_en_c})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/layer_drain.sv
// Reads a contiguous region of layer memory (L0/L1) and streams it out on valid/ready with a last marker.
// DRAIN_CHKSUM_EN adds a 16-bit running sum of the accepted stream words on port chksum.
module layer_drain #(
  parameter int unsigned READ_LAT   = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = atconv_pkg::AW,
  parameter int unsigned DW         = atconv_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          sel_in,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
  output logic          crd,
  output logic [AW-1:0] caddr_rd,
  input  logic [DW-1:0] cdata_rd,
  output logic          csel,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  input  logic          out_ready
`ifdef DRAIN_CHKSUM_EN
  ,
  output logic [15:0]   chksum
`endif
);

  import atconv_pkg::*;

  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SW = $clog2(FIFO_DEPTH + READ_LAT) + 2;
  localparam int unsigned FW = DW + 1;

  drain_state_e state_q, state_d;

  logic                sel_q, sel_d;
  logic [AW-1:0]       next_addr_q, next_addr_d;
  logic [AW-1:0]       caddr_q, caddr_d;
  logic [LW-1:0]       len_q, len_d;
  logic [LW-1:0]       issued_q, issued_d;
  logic [LW-1:0]       push_cnt_q, push_cnt_d;
  logic [READ_LAT-1:0] pipe_q;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                crd_q;
  logic                csel_q, csel_d;

  logic                issue_c, push_c, pop_c, credit_ok_c, push_last_c, head_last_c;
  logic                fifo_empty, fifo_full;
  logic [CW-1:0]       fifo_count;
  logic [FW-1:0]       fifo_rdata;

  // Every issued read that has not yet been accepted holds a FIFO credit.
  assign credit_ok_c = (SW'($countones(pipe_q)) + SW'(fifo_count)) < SW'(FIFO_DEPTH);
  assign push_c      = pipe_q[READ_LAT-1];
  assign push_last_c = (push_cnt_q == len_q - LW'(1));
  assign pop_c       = !fifo_empty && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    next_addr_d = next_addr_q;
    caddr_d     = caddr_q;
    len_d       = len_q;
    issued_d    = issued_q;
    push_cnt_d  = push_c ? push_cnt_q + LW'(1) : push_cnt_q;
    issue_c     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sel_d       = sel_in;
          next_addr_d = base_addr;
          len_d       = length;
          issued_d    = '0;
          push_cnt_d  = '0;
          state_d     = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        issue_c = (issued_q != len_q) && credit_ok_c;
        if (issue_c) begin
          caddr_d     = next_addr_q;
          next_addr_d = next_addr_q + AW'(1);
          issued_d    = issued_q + LW'(1);
        end
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        // The last-tagged word is the final FIFO entry, so its acceptance empties both pipe and FIFO.
        if (pop_c && head_last_c) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    csel_d = busy_d ? sel_d : L0_SEL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q       <= L0_SEL;
      next_addr_q <= '0;
      caddr_q     <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      push_cnt_q  <= '0;
      pipe_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      crd_q       <= 1'b0;
      csel_q      <= L0_SEL;
    end else begin
      sel_q       <= sel_d;
      next_addr_q <= next_addr_d;
      caddr_q     <= caddr_d;
      len_q       <= len_d;
      issued_q    <= issued_d;
      push_cnt_q  <= push_cnt_d;
      pipe_q      <= READ_LAT'({pipe_q, issue_c});
      busy_q      <= busy_d;
      done_q      <= done_d;
      crd_q       <= issue_c;
      csel_q      <= csel_d;
    end
  end

  drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_c),
    .wdata_i ({push_last_c, cdata_rd}),
    .pop_i   (pop_c),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push_c && fifo_full && !pop_c))
        else $error("layer_drain: read return into a full FIFO");
    end
  end

  assign head_last_c = fifo_rdata[FW-1];
  assign busy        = busy_q;
  assign done        = done_q;
  assign crd         = crd_q;
  assign caddr_rd    = caddr_q;
  assign csel        = csel_q;
  assign out_valid   = !fifo_empty;
  assign out_data    = fifo_rdata[DW-1:0];
  assign out_last    = head_last_c && !fifo_empty;

`ifdef DRAIN_CHKSUM_EN
  logic [15:0] chk_q;

  always_ff @(posedge clk) begin
    if (reset)                           chk_q <= '0;
    else if ((state_q == IDLE) && start) chk_q <= '0;
    else if (pop_c)                      chk_q <= chk_q + 16'(out_data);
  end

  assign chksum = chk_q;
`endif

endmodule
